// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: Gray-coded FSM states,
// parity selection values and the minimum oversampling ratio.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_START  = 3'b001,
    ST_DATA   = 3'b011,
    ST_PARITY = 3'b010,
    ST_STOP   = 3'b110
  } uart_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int unsigned MIN_PRESCALE = 8;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with three mid-bit samples and a majority vote.
// bit_end marks edge P-1 of the current bit while the receiver is active.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_rx_in,
  input  logic                      i_start,
  input  logic                      i_active,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic                      o_bit_value_c,
  output logic                      o_bit_end_c
);

  localparam int unsigned PW = PRESCALE_WIDTH;

  logic [PW-1:0] edge_cnt;
  logic [PW-1:0] half;
  logic [PW-1:0] last_edge;
  logic [2:0]    samples;

  assign half          = i_prescale >> 1;
  assign last_edge     = PW'(i_prescale - PW'(1));
  assign o_bit_end_c   = i_active && (edge_cnt == last_edge);
  assign o_bit_value_c = majority3(samples[0], samples[1], samples[2]);

  // Start-detect cycle is edge 0, so the counter resumes at 1 afterwards.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      edge_cnt <= '0;
    end else if (i_start) begin
      edge_cnt <= PW'(1);
    end else if (i_active) begin
      edge_cnt <= o_bit_end_c ? '0 : PW'(edge_cnt + PW'(1));
    end else begin
      edge_cnt <= '0;
    end
  end

  // Samples straddle the bit centre at floor(P/2)-1, floor(P/2), floor(P/2)+1.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      samples <= '0;
    end else if (i_active) begin
      if (edge_cnt == PW'(half - PW'(1))) samples[0] <= i_rx_in;
      if (edge_cnt == half)               samples[1] <= i_rx_in;
      if (edge_cnt == PW'(half + PW'(1))) samples[2] <= i_rx_in;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detection, LSB-first deserialization, optional
// parity check and stop check, with one-cycle result pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_rx_in,
  input  logic                      i_parity_enable,
  input  logic                      i_parity_type,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic                      o_data_valid,
  output logic                      o_parity_error,
  output logic                      o_stop_error,
  output logic                      o_busy
);

  localparam int unsigned PW    = PRESCALE_WIDTH;
  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned CNT_W = (DW > 1) ? $clog2(DW) : 1;

  uart_state_e state, next_state;

  logic [PW-1:0]    prescale_q;
  logic             par_en_q;
  logic             par_odd_q;
  logic [CNT_W-1:0] bit_cnt;
  logic [DW-1:0]    shift_q;
  logic             perr_q;

  logic start_c;
  logic active_c;
  logic bit_value_c;
  logic bit_end_c;
  logic shift_en_c;
  logic par_chk_c;
  logic frame_done_c;

  assign start_c  = (state == ST_IDLE) && !i_rx_in;
  assign active_c = (state != ST_IDLE);

  uart_rx_sampler #(
    .PRESCALE_WIDTH(PW)
  ) u_sampler (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rx_in      (i_rx_in),
    .i_start      (start_c),
    .i_active     (active_c),
    .i_prescale   (prescale_q),
    .o_bit_value_c(bit_value_c),
    .o_bit_end_c  (bit_end_c)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    next_state   = state;
    shift_en_c   = 1'b0;
    par_chk_c    = 1'b0;
    frame_done_c = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!i_rx_in) next_state = ST_START;
      end
      ST_START: begin
        if (bit_end_c) next_state = bit_value_c ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bit_end_c) begin
          shift_en_c = 1'b1;
          if (bit_cnt == CNT_W'(DW - 1)) next_state = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (bit_end_c) begin
          par_chk_c  = 1'b1;
          next_state = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end_c) begin
          frame_done_c = 1'b1;
          next_state   = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Frame configuration and deserializer.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      prescale_q <= PW'(MIN_PRESCALE);
      par_en_q   <= 1'b0;
      par_odd_q  <= PARITY_EVEN;
      bit_cnt    <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
    end else begin
      if (start_c) begin
        prescale_q <= (i_prescale < PW'(MIN_PRESCALE)) ? PW'(MIN_PRESCALE) : i_prescale;
        par_en_q   <= i_parity_enable;
        par_odd_q  <= (i_parity_type == PARITY_ODD);
        bit_cnt    <= '0;
        perr_q     <= 1'b0;
      end
      if (shift_en_c) begin
        shift_q <= {bit_value_c, shift_q[DW-1:1]};
        bit_cnt <= CNT_W'(bit_cnt + CNT_W'(1));
      end
      if (par_chk_c) begin
        perr_q <= ((^shift_q) ^ bit_value_c) != par_odd_q;
      end
    end
  end

  // Registered frame result and busy flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_data         <= '0;
      o_data_valid   <= 1'b0;
      o_parity_error <= 1'b0;
      o_stop_error   <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_busy         <= (next_state != ST_IDLE);
      o_data_valid   <= 1'b0;
      o_parity_error <= 1'b0;
      o_stop_error   <= 1'b0;
      if (frame_done_c) begin
        o_parity_error <= perr_q;
        o_stop_error   <= !bit_value_c;
        if (!perr_q && bit_value_c) begin
          o_data       <= shift_q;
          o_data_valid <= 1'b1;
        end
      end
    end
  end

endmodule
